// File: rtl/mem_writeback_buffer_pkg.sv
// Shared types for the memory write-back buffer.
// Widths, FSM state encoding and the buffered entry layout.
package wb_pkg;

  localparam int ADDR_W  = 28;
  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    READ  = 2'd2
  } state_t;

  typedef struct packed {
    logic               valid;
    logic [ADDR_W-1:0]  address;
    logic [BLOCK_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/mem_writeback_buffer_if.sv
// Cache-side and data-memory-side signals of the write-back buffer.
// slave is the buffer's view; master is the cache core plus memory.
interface mem_writeback_buffer_if;
  import wb_pkg::*;

  logic               cache_read;
  logic               cache_write;
  logic [ADDR_W-1:0]  cache_address;
  logic [BLOCK_W-1:0] cache_writedata;
  logic [BLOCK_W-1:0] cache_readdata;
  logic               cache_busywait;

  logic               mem_read;
  logic               mem_write;
  logic [ADDR_W-1:0]  mem_address;
  logic [BLOCK_W-1:0] mem_writedata;
  logic [BLOCK_W-1:0] mem_readdata;
  logic               mem_busywait;

  modport slave (
    input  cache_read,
    input  cache_write,
    input  cache_address,
    input  cache_writedata,
    output cache_readdata,
    output cache_busywait,
    output mem_read,
    output mem_write,
    output mem_address,
    output mem_writedata,
    input  mem_readdata,
    input  mem_busywait
  );

  modport master (
    output cache_read,
    output cache_write,
    output cache_address,
    output cache_writedata,
    input  cache_readdata,
    input  cache_busywait,
    input  mem_read,
    input  mem_write,
    input  mem_address,
    input  mem_writedata,
    output mem_readdata,
    output mem_busywait
  );

endinterface

// File: rtl/mem_writeback_buffer_match.sv
// wb_entry_match: associative address lookup across all buffer entries.
// One entry (the one being drained) can be masked out of the search.
module wb_entry_match
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IW    = 2
) (
  input  entry_t            entries [DEPTH],
  input  logic [ADDR_W-1:0] addr,
  input  logic              excl_en,
  input  logic [IW-1:0]     excl_idx,
  output logic              hit,
  output logic [IW-1:0]     idx
);

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries[i].valid &&
          entries[i].address == addr &&
          !(excl_en && excl_idx == IW'(i))) begin
        hit = 1'b1;
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/mem_writeback_buffer.sv
// Write-back buffer between a cache core and data memory.
// Define WB_READ_FORWARD_EN to serve reads from buffered blocks.
module mem_writeback_buffer
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                   clock,
  input logic                   reset,
  mem_writeback_buffer_if.slave bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  entry_t             entries [DEPTH];
  logic [IW-1:0]      head;
  logic [IW-1:0]      tail;
  logic [CW-1:0]      count;
  state_t             state;
  state_t             state_nx;
  logic [BLOCK_W-1:0] readdata_q;
  logic               rd_done;

  logic               wr_req;
  logic               rd_req;
  logic               inflight;
  logic               m_hit;
  logic [IW-1:0]      m_idx;
  logic               full;
  logic               push;
  logic               coal;
  logic               pop;
  logic               rd_fin;
  logic               fwd_hit;
  logic               rd_clear;
  logic               rd_miss;

  logic               mem_read;
  logic               mem_write;
  logic [ADDR_W-1:0]  mem_address;
  logic [BLOCK_W-1:0] mem_writedata;

  // A simultaneous read is dropped in favour of the write.
  assign wr_req   = bus.cache_write;
  assign rd_req   = bus.cache_read && !bus.cache_write;
  assign inflight = (state == DRAIN);

  wb_entry_match #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_match (
    .entries  (entries),
    .addr     (bus.cache_address),
    .excl_en  (inflight),
    .excl_idx (head),
    .hit      (m_hit),
    .idx      (m_idx)
  );

  assign full   = (count == CW'(DEPTH));
  assign coal   = wr_req && m_hit;
  assign push   = wr_req && !m_hit && !full;
  assign pop    = inflight && !bus.mem_busywait;
  assign rd_fin = (state == READ) && !bus.mem_busywait;

`ifdef WB_READ_FORWARD_EN
  logic               head_hit;
  logic [BLOCK_W-1:0] fwd_data;

  // The drained head may hold the address while no newer copy exists.
  assign head_hit = inflight &&
                    entries[head].valid &&
                    entries[head].address == bus.cache_address;
  assign fwd_hit  = rd_req && (m_hit || head_hit);
  assign fwd_data = m_hit ? entries[m_idx].data
                          : entries[head].data;
  assign rd_clear = 1'b1;
  assign bus.cache_readdata = fwd_hit ? fwd_data : readdata_q;
`else
  assign fwd_hit  = 1'b0;
  assign rd_clear = (count == '0);
  assign bus.cache_readdata = readdata_q;
`endif

  assign rd_miss = rd_req && !fwd_hit && !rd_done;

  assign bus.cache_busywait =
    reset && (wr_req ? (!m_hit && full) : rd_miss);

  always_comb begin
    state_nx      = state;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    unique case (state)
      IDLE: begin
        if (rd_miss && rd_clear) begin
          state_nx = READ;
        end else if (count != '0) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        mem_write     = 1'b1;
        mem_address   = entries[head].address;
        mem_writedata = entries[head].data;
        if (!bus.mem_busywait) begin
          state_nx = IDLE;
        end
      end
      READ: begin
        mem_read    = 1'b1;
        mem_address = bus.cache_address;
        if (!bus.mem_busywait) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.mem_address   = mem_address;
  assign bus.mem_writedata = mem_writedata;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      readdata_q <= '0;
      rd_done    <= 1'b0;
    end else begin
      rd_done <= rd_fin;
      if (rd_fin) begin
        readdata_q <= bus.mem_readdata;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Push/pop/coalesce never target the same slot in one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (coal) begin
        entries[m_idx].data <= bus.cache_writedata;
      end
      if (push) begin
        entries[tail] <= '{
          valid:   1'b1,
          address: bus.cache_address,
          data:    bus.cache_writedata
        };
      end
      if (pop) begin
        entries[head].valid <= 1'b0;
      end
    end
  end

endmodule
